// File: rtl/trace_sequencer.sv
// trace_sequencer: buffers trace commands in a FIFO and issues them one at a
// time to the L1 cache model. It paces the issue rate, drops illegal ops and
// handshakes the print command with the display side.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready command handshake (in_ready = FIFO not full)
//   in_op, in_addr    incoming command: 4-bit op, 32-bit byte address
//   address           registered {op,addr} of the last issued command
//   iteration         issue counter; increments once per issued command
//   issue             1-cycle strobe that accompanies each address/iteration update
//   clear             1-cycle strobe with issue when the op is 8
//   print_req         held high after an op 9 issue until print_ack is seen
//   print_ack         display done; only looked at while waiting on print
//   err_count         saturating count of dropped illegal ops
//   busy              sequencer not idle or FIFO not empty
module trace_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  output logic [35:0] address,
  output logic [31:0] iteration,
  output logic        issue,
  output logic        clear,
  output logic        print_req,
  input  logic        print_ack,
  output logic [15:0] err_count,
  output logic        busy
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned WORD_W = 36;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PRINT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              push, pop, empty;
  logic [WORD_W-1:0] head;
  logic [3:0]        head_op;

  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [35:0]       address_next;
  logic [31:0]       iteration_next;
  logic              issue_next, clear_next, print_next, busy_next;
  logic [15:0]       err_next;

  // Ops 0-4, 8 and 9 are the only commands the cache model understands.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    unique case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign head_op  = head[35:32];

  // FIFO storage; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_addr};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      address   <= '0;
      iteration <= '0;
      issue     <= 1'b0;
      clear     <= 1'b0;
      print_req <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      address   <= address_next;
      iteration <= iteration_next;
      issue     <= issue_next;
      clear     <= clear_next;
      print_req <= print_next;
      err_count <= err_next;
      busy      <= busy_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    hold_next      = hold_cnt;
    pop            = 1'b0;
    address_next   = address;
    iteration_next = iteration;
    issue_next     = 1'b0;
    clear_next     = 1'b0;
    err_next       = err_count;

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (!op_legal(head_op)) begin
            if (err_count != 16'hFFFF) err_next = err_count + 16'd1;
          end else begin
            address_next   = head;
            iteration_next = iteration + 32'd1;
            issue_next     = 1'b1;
            clear_next     = (head_op == 4'd8);
            if (head_op == 4'd9) begin
              state_next = PRINT;
            end else if (HOLD_CYCLES != 0) begin
              state_next = HOLD;
              hold_next  = HOLD_INIT;
            end
          end
        end
      end
      HOLD: begin
        // Leave on the cycle the counter reads 1: exactly HOLD_CYCLES cycles here.
        if (hold_cnt <= HOLD_W'(1)) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_cnt - HOLD_W'(1);
        end
      end
      PRINT: begin
        if (print_ack) begin
          if (HOLD_CYCLES != 0) begin
            state_next = HOLD;
            hold_next  = HOLD_INIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    print_next = (state_next == PRINT);
    busy_next  = (state_next != IDLE) || (count_next != '0);
  end

endmodule
